// File: rtl/cnn_pkg.sv
// cnn_pkg: shared output-memory geometry and drain FSM state type
package cnn_pkg;
   localparam int WIDTH = 16;
   localparam int SIZE  = 64;
   typedef enum logic {IDLE, RUN} drain_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry FIFO absorbing the one-cycle memory read latency
module skid_fifo2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       occ
);
   logic [WIDTH-1:0] slot [2];
   logic wr_ptr, rd_ptr;
   assign data_out = slot[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         occ     <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= data_in;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/output_stream_drain.sv
// output_stream_drain: reads N results from the output memory starting at address 0
// and streams them in address order over valid/ready through a two-entry skid FIFO
module output_stream_drain #(
   parameter  int WIDTH   = cnn_pkg::WIDTH,
   parameter  int SIZE    = cnn_pkg::SIZE,
   localparam int LOGSIZE = $clog2(SIZE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [LOGSIZE:0]   num_outputs,
   output logic               busy,
   output logic               done,
   output logic               mem_rd_en,
   output logic [LOGSIZE-1:0] mem_rd_addr,
   input  logic [WIDTH-1:0]   mem_data,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready
);
   import cnn_pkg::*;
   localparam logic [LOGSIZE:0] MAX_N = (LOGSIZE+1)'(SIZE);
   drain_state_t state;
   logic [LOGSIZE:0] n, issued, popped;
   logic inflight, pop;
   logic [1:0] occ;
   assign out_valid   = occ != 2'd0;
   assign pop         = out_valid && out_ready;
   // buffered plus in-flight words never exceed the two FIFO slots
   assign mem_rd_en   = state == RUN && issued < n && 3'(occ) + 3'(inflight) - 3'(pop) < 3'd2;
   assign mem_rd_addr = issued[LOGSIZE-1:0];
   skid_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (inflight),
      .pop      (pop),
      .data_in  (mem_data),
      .data_out (out_data),
      .occ      (occ)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         n        <= '0;
         issued   <= '0;
         popped   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= mem_rd_en;
         done     <= 1'b0;
         issued   <= issued + {{LOGSIZE{1'b0}}, mem_rd_en};
         popped   <= popped + {{LOGSIZE{1'b0}}, pop};
         if (state == IDLE && start) begin
            state  <= RUN;
            busy   <= 1'b1;
            issued <= '0;
            popped <= '0;
            n      <= num_outputs > MAX_N ? MAX_N : num_outputs;
         end else if (state == RUN && popped + {{LOGSIZE{1'b0}}, pop} == n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end
      end
endmodule

// File: tb/tb_output_stream_drain.sv
// tb_output_stream_drain: randomized drains scored against an address-order queue model
// of the memory contents, with literal latency/count expectations per scenario
module tb_output_stream_drain;
   import cnn_pkg::*;
   localparam int W  = WIDTH;
   localparam int S  = SIZE;
   localparam int LS = $clog2(S);

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic [LS:0]   num_outputs = '0;
   logic          busy, done, mem_rd_en, out_valid;
   logic [LS-1:0] mem_rd_addr;
   logic [W-1:0]  mem_data = '0, out_data, prev_data = '0;
   logic [W-1:0]  mem [S];
   logic [W-1:0]  exp_q [$];

   int errors = 0, checks = 0, cyc = 0;
   int n_exp = 0, reads = 0, beats = 0, done_cnt = 0;
   int done_due = 0, prev_stall = 0, ready_mode = 0, stall_cnt = 0;
   int s_cyc = 0, first_beat_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
   int rd_run = 0, max_rd_run = 0, max_addr = 0, valid_seen = 0;

   output_stream_drain #(.WIDTH(W), .SIZE(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_outputs (num_outputs),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_data    (mem_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_data <= mem[mem_rd_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: begin out_ready = 1'b1; stall_cnt = 0; end
         1: begin out_ready = ~out_ready; stall_cnt = 0; end
         2: begin out_ready = $urandom_range(0, 3) != 0; stall_cnt = 0; end
         default: begin
            out_ready = !(beats >= 2 && stall_cnt < 10);
            if (!out_ready) stall_cnt++;
         end
      endcase
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
         done_due   = 0;
         rd_run     = 0;
      end else begin
         chk("occupancy_le2", 32'(reads - beats <= 2), 1);
         if (n_exp > 0) chk("done_pulse", done, done_due);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
         end
         if (mem_rd_en || out_valid) chk("busy_active", busy, 1);
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid) valid_seen++;
         if (mem_rd_en) begin
            chk("rd_addr", mem_rd_addr, reads);
            chk("rd_in_range", 32'(reads < n_exp), 1);
            reads++;
            rd_run++;
            if (int'(mem_rd_addr) > max_addr) max_addr = int'(mem_rd_addr);
            if (rd_run > max_rd_run) max_rd_run = rd_run;
         end else rd_run = 0;
         done_due = 0;
         if (out_valid && out_ready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("beat_data", out_data, exp_q.pop_front());
            if (beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats++;
            done_due = int'(beats == n_exp);
         end
         prev_stall = int'(out_valid && !out_ready);
         prev_data  = out_data;
      end
   end

   task automatic fill(input int kind);
      for (int i = 0; i < S; i++) mem[i] = kind == 0 ? W'(3 * i) : W'($urandom);
   endtask

   task automatic start_drain(input int n);
      @(posedge clk);
      #1;
      n_exp = n > S ? S : n;
      exp_q.delete();
      for (int i = 0; i < n_exp; i++) exp_q.push_back(mem[i]);
      reads = 0; beats = 0; done_cnt = 0; valid_seen = 0;
      max_rd_run = 0; max_addr = 0; first_beat_cyc = -1; done_cyc = -1;
      start = 1'b1;
      num_outputs = n[LS:0];
      s_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done_within_budget", 32'(done_cnt > 0), 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("beat_count", beats, n_exp);
      chk("read_count", reads, n_exp);
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int k;
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_addr", mem_rd_addr, 0);
      chk("rst_data", out_data, 0);
      @(negedge clk) rst_n = 1'b1;

      // throughput
      ready_mode = 0;
      start_drain(8);
      chk("tp_valid_e0", out_valid, 0);
      chk("tp_rd_en_e0", mem_rd_en, 1);
      chk("tp_busy_e0", busy, 1);
      @(posedge clk);
      #1 chk("tp_valid_e1", out_valid, 0);
      @(posedge clk);
      #1;
      chk("tp_valid_e2", out_valid, 1);
      chk("tp_data_e2", out_data, 0);
      wait_done(50);
      chk("tp_first_beat_lat", first_beat_cyc - s_cyc, 3);
      chk("tp_beat_span", last_beat_cyc - first_beat_cyc, 7);
      chk("tp_done_after_last", done_cyc - last_beat_cyc, 1);
      chk("tp_rd_run", max_rd_run, 8);

      // long stall holding word 6 at the head
      ready_mode = 3;
      start_drain(16);
      k = 0;
      while (stall_cnt < 6 && k < 100) begin @(negedge clk); k++; end
      chk("stall_data", out_data, 6);
      chk("stall_valid", out_valid, 1);
      chk("stall_no_rd", mem_rd_en, 0);
      wait_done(200);

      // zero length
      ready_mode = 0;
      start_drain(0);
      chk("zero_busy", busy, 1);
      wait_done(10);
      chk("zero_done_lat", done_cyc - s_cyc, 2);
      chk("zero_no_valid", valid_seen, 0);

      // backpressure
      fill(1);
      ready_mode = 1;
      start_drain(64);
      wait_done(1000);

      // clamp
      fill(1);
      ready_mode = 2;
      start_drain(100);
      wait_done(1000);
      chk("clamp_beats", beats, 64);
      chk("clamp_max_addr", max_addr, 63);

      // second start while busy is ignored
      fill(1);
      start_drain(20);
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1;
      num_outputs = 5;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(500);
      chk("busy_start_beats", beats, 20);

      // asynchronous reset mid-drain
      fill(1);
      ready_mode = 0;
      start_drain(20);
      k = 0;
      while (beats < 5 && k < 100) begin @(negedge clk); k++; end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rd_en", mem_rd_en, 0);
      n_exp = 0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      fill(1);
      start_drain(4);
      wait_done(50);
      chk("arst_restart_beats", beats, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
